// File: rtl/divider_pkg.sv
// divider_pkg -- shared types and constants for the multi-cycle divider.
//
// Contents:
//   div_state_t : FSM state encoding (IDLE, CALC, DONE)
//   DIV_WIDTH   : default operand/result width
//   DIV_CNT_W   : iteration counter width for DIV_WIDTH
//   DIV_ZERO_Q  : quotient returned on divide-by-zero (all ones)
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division iteration.
//
// Ports:
//   rem_in  [WIDTH:0]   : partial remainder before this step
//   dvd_bit             : next dividend bit (MSB first)
//   dvs     [WIDTH-1:0] : divisor magnitude
//   rem_out [WIDTH:0]   : partial remainder after this step
//   q_bit               : quotient bit produced by this step
//
// Kept apart from the FSM so that a second instance can later be chained
// to retire two quotient bits per clock.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    // One guard bit above the WIDTH+1-bit trial difference: its top bit is
    // the borrow, i.e. "remainder < divisor".
    diff    = shifted - {2'b00, dvs};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divider_32bit.sv
// divider_32bit -- multi-cycle restoring integer divider, one quotient bit
// per clock, start/valid handshake.
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : request a division (sampled only when busy=0)
//   signed_op       : 1 = signed, 0 = unsigned (only with DIVIDER_SIGNED_EN)
//   a, b            : dividend, divisor
//   busy            : operation in progress (CALC)
//   valid           : one-cycle pulse in the cycle Q/R are updated
//   Q, R            : quotient, remainder (hold until next result)
//   dbg_state       : current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0 (state IDLE or DONE); start while busy=1 is ignored. The result
// is presented with valid=1 for exactly one cycle, with no back-pressure.
//
// Build option: define DIVIDER_SIGNED_EN to compile in signed division
// (magnitude conversion and result negation). Without it, all operations
// are unsigned and signed_op is not used.
module divider_32bit
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output div_state_t       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;      // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH:0]   rem;      // partial remainder
  logic [WIDTH-1:0] quo;      // quotient bits collected so far

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept    = start && (state != CALC);
  assign b_zero    = (b == '0);
  assign busy      = (state == CALC);
  assign valid     = (state == DONE);
  assign dbg_state = state;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .dvs     (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Result of the final iteration, taken straight from the step outputs so
  // Q/R can be loaded on the same edge that enters DONE.
  assign q_raw = {quo[WIDTH-2:0], step_q};
  assign r_raw = step_rem[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Truncating division: quotient negative when signs differ, remainder
  // follows the dividend. The most-negative / -1 case wraps naturally.
  assign q_fin = neg_q ? (~q_raw + 1'b1) : q_raw;
  assign r_fin = neg_r ? (~r_raw + 1'b1) : r_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_mag = a;
  assign b_mag = b;
  assign q_fin = q_raw;
  assign r_fin = r_raw;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start)      state_next = b_zero ? DONE : CALC;
        else            state_next = IDLE;
      end
      CALC: begin
        if (cnt == '0)  state_next = DONE;
      end
      default:          state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      Q   <= '0;
      R   <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(WIDTH - 1);
      dvd <= a_mag;
      dvs <= b_mag;
      rem <= '0;
      quo <= '0;
      if (b_zero) begin
        // Raw dividend, regardless of signed_op.
        Q <= '1;
        R <= a;
      end
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      rem <= step_rem;
      quo <= q_raw;
      if (cnt == '0) begin
        Q <= q_fin;
        R <= r_fin;
      end
    end
  end

endmodule

// File: tb/tb_divider_32bit.sv
// tb_divider_32bit -- self-checking bench for divider_32bit.
// Expected results come from a plain-arithmetic reference model; latency,
// busy duration, result hold, ignored start, back-to-back and reset abort
// are checked along the way.
module tb_divider_32bit;
  import divider_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         valid;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  div_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res = '0;

  divider_32bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid     (valid),
    .Q         (Q),
    .R         (R),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {Q, R} from the arithmetic definition of division.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] da, input logic [W-1:0] db,
                                           input logic s);
    longint sa, sb, lq, lr;
    logic [W-1:0] q, r;
    if (db == '0) return {{W{1'b1}}, da};
`ifdef DIVIDER_SIGNED_EN
    if (s) begin
      sa = longint'($signed(da));
      sb = longint'($signed(db));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
      return {q, r};
    end
`endif
    q = da / db;
    r = da % db;
    return {q, r};
  endfunction

  // Drive a request at the current negedge; accepted on the next posedge.
  task automatic start_op(input logic [W-1:0] da, input logic [W-1:0] db, input logic s);
    exp_q.push_back(model(da, db, s));
    a         = da;
    b         = db;
    signed_op = s;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at the negedge of the first cycle after acceptance. Returns at the
  // negedge of the valid cycle. poke_at>0 raises start in that busy cycle.
  task automatic wait_result(input int exp_lat, input int poke_at, input bit hold_chk);
    int cycles;
    int busy_cnt;
    logic [2*W-1:0] e;
    cycles   = 1;
    busy_cnt = 0;
    while (!valid && cycles < 100) begin
      if (busy) busy_cnt++;
      if (hold_chk && cycles == 5) check("hold_qr", {Q, R}, last_res);
      if (cycles == poke_at) begin
        a         = $urandom;
        b         = $urandom_range(1, 1000);
        signed_op = 1'($urandom_range(0, 1));
        start     = 1'b1;
      end else if (cycles == poke_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!valid) begin
      check("timeout", 0, 1);
      return;
    end
    check("latency", cycles, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat - 1);
    check("busy_in_done", busy, 0);
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("quotient", Q, e[2*W-1:W]);
    check("remainder", R, e[W-1:0]);
    last_res = e;
  endtask

  initial begin : main
    int vcnt;
    logic [W-1:0] ra, rb;
    int sel;

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", dbg_state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);

    // 100 / 7 unsigned
    start_op(32'd100, 32'd7, 1'b0);
    wait_result(33, 0, 1);
    @(negedge clk);

    // divide by zero
    start_op(32'h12345678, 32'd0, 1'b0);
    wait_result(1, 0, 0);
    @(negedge clk);

    // signed-class cases (unsigned results without DIVIDER_SIGNED_EN)
    start_op(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_result(33, 0, 1);
    start_op(32'd7, 32'hFFFFFFFE, 1'b1);
    wait_result(33, 0, 1);
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_result(33, 0, 1);

    // start pulsed mid-CALC ignored, then back-to-back accept in DONE
    start_op(32'd1000003, 32'd97, 1'b0);
    wait_result(33, 10, 1);
    start_op(32'hDEADBEEF, 32'd12345, 1'b0);
    wait_result(33, 0, 1);

    // back-to-back divide-by-zero
    start_op(32'h55AA55AA, 32'd0, 1'b1);
    wait_result(1, 0, 0);
    start_op(32'h0000BEEF, 32'd0, 1'b0);
    wait_result(1, 0, 0);
    @(negedge clk);

    // reset during iteration 10
    start_op(32'hCAFEF00D, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    last_res = '0;
    check("abort_state", dbg_state, IDLE);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_q", Q, 0);
    check("abort_r", R, 0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) vcnt++;
      @(negedge clk);
    end
    check("no_valid_after_rst", vcnt, 0);

    // randomized operations, back-to-back
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case (sel)
        0:       rb = '0;
        1, 2, 3: rb = $urandom_range(1, 15);
        4:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      start_op(ra, rb, 1'($urandom_range(0, 1)));
      wait_result((rb == '0) ? 1 : 33, 0, 1);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
